// File: rtl/alu_pkg.sv
// Shared encodings for the execute-side ALU and its arbiter.
// Function selects, condition-code bit positions and reset CC value.
package alu_pkg;

    localparam logic [1:0] FN_ADD = 2'd0;
    localparam logic [1:0] FN_SUB = 2'd1;
    localparam logic [1:0] FN_AND = 2'd2;
    localparam logic [1:0] FN_XOR = 2'd3;

    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    localparam logic [2:0] CC_RESET_DEF = 3'b100;

endpackage

// File: rtl/alu.sv
// Shared 64-bit combinational ALU datapath.
// Select 0..4: add, sub, and, xor, or; other codes yield zero.
module alu #(
    parameter int W = 64
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [3:0]   s,
    output logic [W-1:0] Out
);

    always_comb begin
        Out = '0;
        case (s)
            4'd0:    Out = A + B;
            4'd1:    Out = A - B;
            4'd2:    Out = A & B;
            4'd3:    Out = A ^ B;
            4'd4:    Out = A | B;
            default: Out = '0;
        endcase
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with its pointer register.
// The pointer moves to the other requester only when a grant is issued.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (|gnt) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between the E-stage and address arithmetic,
// with a one-entry result slot and the Y86 condition codes.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int         W        = 64,
    parameter logic [2:0] CC_RESET = CC_RESET_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [1:0]   req0_fn,
    input  logic [1:0]   req1_fn,
    input  logic [1:0]   req_set_cc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_id,
    output logic [2:0]   cc
);

    logic         free;
    logic         en;
    logic [1:0]   gnt;
    logic         granted;
    logic         idx;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   fn;
    logic [W-1:0] res;
    logic         of;
    logic [2:0]   cc_next;

    assign free      = !out_valid || out_ready;
    assign en        = free && !flush && !rst;
    assign req_ready = gnt;
    assign granted   = |gnt;
    assign idx       = gnt[1];

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .req (req_valid),
        .gnt (gnt)
    );

    assign a  = idx ? req1_a : req0_a;
    assign b  = idx ? req1_b : req0_b;
    assign fn = idx ? req1_fn : req0_fn;

    alu #(.W(W)) u_alu (
        .A   (a),
        .B   (b),
        .s   ({2'b00, fn}),
        .Out (res)
    );

    // Signed overflow only exists for add/sub; logic ops clear it.
    always_comb begin
        of = 1'b0;
        unique case (fn)
            FN_ADD:  of = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
            FN_SUB:  of = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
            default: of = 1'b0;
        endcase
        cc_next        = 3'b000;
        cc_next[CC_ZF] = (res == '0);
        cc_next[CC_SF] = res[W-1];
        cc_next[CC_OF] = of;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= 1'b0;
            cc        <= CC_RESET;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (granted) begin
            out_valid <= 1'b1;
            out_data  <= res;
            out_id    <= idx;
            if (req_set_cc[idx]) begin
                cc <= cc_next;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  req0_fn, req1_fn;
    logic [1:0]  req_set_cc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_id;
    logic [2:0]  cc;

    int tests = 0;
    int fails = 0;

    alu_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req0_fn    (req0_fn),
        .req1_fn    (req1_fn),
        .req_set_cc (req_set_cc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id),
        .cc         (cc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: slot contents, CC and who is owed the next tie.
    logic        m_known = 1'b0;
    logic        m_valid;
    logic [63:0] m_data;
    logic        m_id;
    logic [2:0]  m_cc;
    logic        m_next;

    function automatic logic [63:0] f_res(input logic [63:0] x,
                                          input logic [63:0] y,
                                          input logic [1:0] f);
        case (f)
            2'd0:    return x + y;
            2'd1:    return x - y;
            2'd2:    return x & y;
            default: return x ^ y;
        endcase
    endfunction

    // Overflow = exact signed result does not fit in 64 bits.
    function automatic logic f_of(input logic [63:0] x,
                                  input logic [63:0] y,
                                  input logic [1:0] f);
        logic signed [64:0] t;
        t = '0;
        if (f == 2'd0) t = $signed({x[63], x}) + $signed({y[63], y});
        else if (f == 2'd1) t = $signed({x[63], x}) - $signed({y[63], y});
        else return 1'b0;
        return t[64] != t[63];
    endfunction

    function automatic logic [1:0] exp_ready();
        if (rst || flush) return 2'b00;
        if (m_valid && !out_ready) return 2'b00;
        case (req_valid)
            2'b01:   return 2'b01;
            2'b10:   return 2'b10;
            2'b11:   return m_next ? 2'b10 : 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    always @(negedge clk) begin
        logic [1:0]  g;
        logic        w;
        logic [63:0] x, y, r;
        logic [1:0]  f;
        g = exp_ready();
        chk("req_ready", {62'd0, req_ready}, {62'd0, g});
        if (m_known) begin
            chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
            chk("out_data", out_data, m_data);
            chk("out_id", {63'd0, out_id}, {63'd0, m_id});
            chk("cc", {61'd0, cc}, {61'd0, m_cc});
        end
        if (rst) begin
            m_known = 1'b1;
            m_valid = 1'b0;
            m_data  = '0;
            m_id    = 1'b0;
            m_cc    = 3'b100;
            m_next  = 1'b0;
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (g != 2'b00) begin
            w = (g == 2'b10);
            x = w ? req1_a : req0_a;
            y = w ? req1_b : req0_b;
            f = w ? req1_fn : req0_fn;
            r = f_res(x, y, f);
            m_valid = 1'b1;
            m_data  = r;
            m_id    = w;
            m_next  = !w;
            if (req_set_cc[w]) m_cc = {r == 64'd0, r[63], f_of(x, y, f)};
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'h8000_0000_0000_0000;
            2:       return 64'hFFFF_FFFF_FFFF_FFFF;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            4:       return 64'($urandom_range(0, 15));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = 2'b11; out_ready = 1'b1;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        req0_fn = 2'd0; req1_fn = 2'd0; req_set_cc = 2'b00;
        tick();
        tick();
        chk("rst_ready", {62'd0, req_ready}, 64'd0);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_cc", {61'd0, cc}, 64'd4);
        chk("rst_data", out_data, 64'd0);

        rst = 1'b0; req_valid = 2'b01;
        req0_a = 64'd5; req0_b = 64'd7; req0_fn = 2'd0; req_set_cc = 2'b01;
        chk("add_ready", {62'd0, req_ready}, 64'd1);
        tick();
        req_valid = 2'b00; req_set_cc = 2'b00;
        chk("add_data", out_data, 64'd12);
        chk("add_id", {63'd0, out_id}, 64'd0);
        chk("add_cc", {61'd0, cc}, 64'd0);

        rst = 1'b1; tick(); rst = 1'b0;
        req_valid = 2'b11;
        req0_a = 64'd100; req0_b = 64'd1; req0_fn = 2'd0;
        req1_a = 64'd100; req1_b = 64'd1; req1_fn = 2'd1;
        for (int i = 0; i < 4; i++) begin
            chk("rr_ready", {62'd0, req_ready}, (i % 2) ? 64'd2 : 64'd1);
            tick();
            chk("rr_id", {63'd0, out_id}, 64'(i % 2));
            chk("rr_data", out_data, (i % 2) ? 64'd99 : 64'd101);
        end

        req_valid = 2'b10; req_set_cc = 2'b10;
        req1_a = 64'h8000_0000_0000_0000; req1_b = 64'd1; req1_fn = 2'd1;
        tick();
        chk("ovf_data", out_data, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("ovf_cc", {61'd0, cc}, 64'd1);
        req1_a = 64'hDEAD; req1_b = 64'hDEAD; req1_fn = 2'd3;
        tick();
        chk("zero_data", out_data, 64'd0);
        chk("zero_cc", {61'd0, cc}, 64'd4);

        req_set_cc = 2'b00; req_valid = 2'b11; out_ready = 1'b0;
        req1_a = 64'd100; req1_b = 64'd1; req1_fn = 2'd1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_ready", {62'd0, req_ready}, 64'd0);
            tick();
            chk("bp_data", out_data, 64'd0);
        end
        out_ready = 1'b1;
        chk("bp_release", {62'd0, req_ready}, 64'd1);
        tick();
        chk("bp_id", {63'd0, out_id}, 64'd0);
        chk("bp_next", {62'd0, req_ready}, 64'd2);

        req_valid = 2'b01; flush = 1'b1; req_set_cc = 2'b01;
        req0_a = 64'd1; req0_b = 64'd1; req0_fn = 2'd0;
        chk("fl_ready", {62'd0, req_ready}, 64'd0);
        tick();
        chk("fl_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_cc", {61'd0, cc}, 64'd4);
        flush = 1'b0;
        chk("fl_regrant", {62'd0, req_ready}, 64'd1);
        tick();
        chk("fl_data", out_data, 64'd2);
        chk("fl_cc2", {61'd0, cc}, 64'd0);

        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 63) == 0);
            flush      = ($urandom_range(0, 7) == 0);
            req_valid  = 2'($urandom_range(0, 3));
            out_ready  = ($urandom_range(0, 3) != 0);
            req_set_cc = 2'($urandom_range(0, 3));
            req0_a = pick(); req0_b = pick();
            req1_a = pick(); req1_b = pick();
            req0_fn = 2'($urandom_range(0, 3));
            req1_fn = 2'($urandom_range(0, 3));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 64-bit ALU datapath between two execute-side requesters: port 0 is the pipeline E-stage OPq; port 1 is address/stack-pointer arithmetic.
- Arbitrates round-robin and drives the ALU function select.
- Registers the result into a one-entry output slot with valid/ready backpressure.
- Owns the Y86 condition-code register (ZF, SF, OF).

Parameters:
- W, 64, operand/result width; must match the ALU.
- CC_RESET, 3'b100, reset value of {ZF,SF,OF}.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush (mispredict); synchronous.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester grant; a transfer occurs when valid&ready.
- req0_a, req0_b  in  W each  requester 0 operands.
- req1_a, req1_b  in  W each  requester 1 operands.
- req0_fn, req1_fn  in  2 each  0=add, 1=sub (a-b), 2=and, 3=xor.
- req_set_cc  in  2  per-requester: update CC with this op.
- out_valid  out  1  result slot occupied.
- out_ready  in  1  consumer accepts result.
- out_data  out  W  registered ALU result.
- out_id  out  1  index of the requester that produced out_data.
- cc  out  3  {ZF,SF,OF} register.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_id=0.
  - cc=CC_RESET; RR pointer=0.
  - rst overrides flush and any in-flight handshake; req_ready is 0 while rst=1.
- Slot free (combinational): free = !out_valid | out_ready.
- Grant (combinational):
  - If flush or rst, or !free: req_ready=0.
  - Otherwise, if exactly one req_valid bit is set, grant that requester.
  - If both are set, grant the requester the pointer indicates.
  - At most one req_ready bit is high in any cycle.
- ALU drive: operands and fn are muxed from the granted requester. The ALU select is s={2'b00,fn}; upper select bits are always 0.
- Latency: 1 cycle. On a grant edge:
  - out_data<=ALU result, out_id<=granted index, out_valid<=1.
  - Pointer <= the other requester (pointer changes only on a grant).
- Drain: if out_valid & out_ready and no grant this cycle, out_valid<=0. A drain and a grant in the same cycle keeps out_valid=1 with the new data (back-to-back, full throughput).
- Hold: if out_valid & !out_ready, out_data and out_id stay stable and no grants occur.
- CC update: on a grant edge when the granted requester's set_cc=1:
  - ZF = (res==0); SF = res[W-1].
  - OF for add: a[W-1]==b[W-1] && res[W-1]!=a[W-1].
  - OF for sub: a[W-1]!=b[W-1] && res[W-1]!=a[W-1].
  - OF for and/xor: 0.
  - Otherwise cc holds.
- Flush (flush=1 at an edge, rst=0):
  - out_valid<=0 (slot discarded).
  - No grant; cc and pointer unchanged.
  - Requests held valid are serviced from the next cycle.
- Width rule: all arithmetic is modulo 2^W; no carry/borrow output.
- Requesters must hold operands/fn stable while valid&!ready. The block does not check this.

Decomposition:
- Shared package alu_pkg:
  - fn encodings (FN_ADD=0, FN_SUB=1, FN_AND=2, FN_XOR=3).
  - CC bit indices (CC_ZF=2, CC_SF=1, CC_OF=0).
  - Default CC_RESET.
- Sub-modules:
  - The existing 64-bit ALU module (ports A, B, s, Out), instantiated once, unchanged.
  - Optionally rr_arb2: the 2-way round-robin grant plus pointer register.

Test Plan:
- Reset: assert rst 2 cycles with both req_valid=1 -> req_ready=0, out_valid=0, cc=3'b100, out_data=0 throughout.
- Single add: req0 a=5, b=7, fn=0, set_cc=1, out_ready=1 -> next cycle out_valid=1, out_data=12, out_id=0, cc=3'b000.
- Contention: both valid every cycle, out_ready=1 -> grants alternate 0,1,0,1 starting with 0. Each out_id matches; one result per cycle.
- Overflow/zero:
  - req1 sub a=0x8000_0000_0000_0000, b=1, set_cc=1 -> out_data=0x7FFF_FFFF_FFFF_FFFF, cc=3'b001.
  - Then xor a=b=0xDEAD, set_cc=1 -> out_data=0, cc=3'b100.
- Backpressure: out_ready=0 for 3 cycles after a result -> req_ready=0, out_data stable. Raise out_ready -> same-cycle grant; pointer order preserved.
- Flush: flush=1 while out_valid=1 and req0 valid with set_cc=1 -> out_valid drops next cycle, cc unchanged, no grant. The request is granted the cycle after flush deasserts.
